// File: rtl/pixel_scan_ctrl.sv
// Pixel oscillator scan controller: walks the enabled channels, lets each oscillator settle,
// counts its pulses over a gate window and offers the result on a valid/ready channel.
module pixel_scan_ctrl #(
   parameter int N_PX       = 24,
   parameter int CNT_W      = 32,
   parameter int GATE_W     = 16,
   parameter int SETTLE_CYC = 4,
   localparam int AW        = $clog2(N_PX)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              cont_mode,
   input  logic [N_PX-1:0]   ch_mask,
   input  logic [GATE_W-1:0] gate_len,
   input  logic              px_pulse,
   output logic [AW-1:0]     px_addr,
   output logic [N_PX-1:0]   stop_osc,
   output logic [CNT_W-1:0]  out_data,
   output logic [AW-1:0]     out_addr,
   output logic              out_ovf,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              sweep_done
);

   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int TW = (GATE_W > SW) ? GATE_W : SW;

   typedef enum logic [1:0] {IDLE, SETTLE, COUNT, HOLD} state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     px_addr_q, px_addr_d;
   logic [N_PX-1:0]   stop_osc_q, stop_osc_d;
   logic [N_PX-1:0]   mask_q, mask_d;
   logic [GATE_W-1:0] gate_q, gate_d;
   logic              cont_q, cont_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [CNT_W-1:0]  out_data_q, out_data_d;
   logic [AW-1:0]     out_addr_q, out_addr_d;
   logic              out_ovf_q, out_ovf_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [AW-1:0]     start_low, mask_low, next_ch;
   logic              next_found;
   logic [CNT_W-1:0]  cnt_inc;
   logic              ovf_inc;
   logic              launch;
   logic [AW-1:0]     launch_ch;

   function automatic logic [N_PX-1:0] run_mask(input logic [AW-1:0] a);
      run_mask = ~(N_PX'(1) << a);
   endfunction

   // Descending scan so the last hit is the lowest qualifying channel.
   always_comb begin
      start_low  = '0;
      mask_low   = '0;
      next_ch    = '0;
      next_found = 1'b0;
      for (int i = N_PX - 1; i >= 0; i--) begin
         if (ch_mask[i]) start_low = AW'(i);
         if (mask_q[i]) mask_low = AW'(i);
         if (mask_q[i] && (i > int'(px_addr_q))) begin
            next_ch    = AW'(i);
            next_found = 1'b1;
         end
      end
   end

   always_comb begin
      cnt_inc = cnt_q;
      ovf_inc = ovf_q;
      if (px_pulse) begin
         if (&cnt_q) ovf_inc = 1'b1;
         else        cnt_inc = cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      px_addr_d   = px_addr_q;
      stop_osc_d  = stop_osc_q;
      mask_d      = mask_q;
      gate_d      = gate_q;
      cont_d      = cont_q;
      timer_d     = timer_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      out_ovf_d   = out_ovf_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      launch      = 1'b0;
      launch_ch   = '0;

      if (abort) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         stop_osc_d  = '1;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && (ch_mask != '0)) begin
                  mask_d    = ch_mask;
                  gate_d    = (gate_len == '0) ? GATE_W'(1) : gate_len;
                  cont_d    = cont_mode;
                  launch    = 1'b1;
                  launch_ch = start_low;
               end
            end
            SETTLE: begin
               if (timer_q == '0) begin
                  timer_d = TW'(gate_q - GATE_W'(1));
                  state_d = COUNT;
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
            COUNT: begin
               cnt_d = cnt_inc;
               ovf_d = ovf_inc;
               if (timer_q == '0) begin
                  out_data_d  = cnt_inc;
                  out_ovf_d   = ovf_inc;
                  out_addr_d  = px_addr_q;
                  out_valid_d = 1'b1;
                  stop_osc_d  = '1;
                  state_d     = HOLD;
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid_d = 1'b0;
                  if (next_found) begin
                     launch    = 1'b1;
                     launch_ch = next_ch;
                  end else begin
                     done_d = 1'b1;
                     if (cont_q) begin
                        launch    = 1'b1;
                        launch_ch = mask_low;
                     end else begin
                        state_d = IDLE;
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase

         // Every entry into SETTLE powers up only the selected oscillator and restarts the window.
         if (launch) begin
            px_addr_d  = launch_ch;
            stop_osc_d = run_mask(launch_ch);
            cnt_d      = '0;
            ovf_d      = 1'b0;
            timer_d    = TW'(SETTLE_CYC - 1);
            state_d    = SETTLE;
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         px_addr_q   <= '0;
         stop_osc_q  <= '1;
         mask_q      <= '0;
         gate_q      <= '0;
         cont_q      <= 1'b0;
         timer_q     <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         px_addr_q   <= px_addr_d;
         stop_osc_q  <= stop_osc_d;
         mask_q      <= mask_d;
         gate_q      <= gate_d;
         cont_q      <= cont_d;
         timer_q     <= timer_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         out_ovf_q   <= out_ovf_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign px_addr    = px_addr_q;
   assign stop_osc   = stop_osc_q;
   assign out_data   = out_data_q;
   assign out_addr   = out_addr_q;
   assign out_ovf    = out_ovf_q;
   assign out_valid  = out_valid_q;
   assign busy       = busy_q;
   assign sweep_done = done_q;

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Randomized bench for pixel_scan_ctrl; expectations come from a timing/sum model that predicts
// when each result appears and what it holds from the recorded pulse history.
module tb_pixel_scan_ctrl;

   localparam int N_PX       = 24;
   localparam int CNT_W      = 4;
   localparam int GATE_W     = 16;
   localparam int SETTLE_CYC = 4;
   localparam int AW         = $clog2(N_PX);
   localparam int CNT_MAX    = (1 << CNT_W) - 1;
   localparam int HIST       = 16384;

   logic              clk;
   logic              rst;
   logic              start;
   logic              abort;
   logic              cont_mode;
   logic [N_PX-1:0]   ch_mask;
   logic [GATE_W-1:0] gate_len;
   logic              px_pulse;
   logic [AW-1:0]     px_addr;
   logic [N_PX-1:0]   stop_osc;
   logic [CNT_W-1:0]  out_data;
   logic [AW-1:0]     out_addr;
   logic              out_ovf;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic              sweep_done;

   pixel_scan_ctrl #(
      .N_PX(N_PX), .CNT_W(CNT_W), .GATE_W(GATE_W), .SETTLE_CYC(SETTLE_CYC)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .cont_mode(cont_mode),
      .ch_mask(ch_mask), .gate_len(gate_len), .px_pulse(px_pulse), .px_addr(px_addr),
      .stop_osc(stop_osc), .out_data(out_data), .out_addr(out_addr), .out_ovf(out_ovf),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .sweep_done(sweep_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cmp_count;
   int err_count;
   int cyc;
   bit pulse_hist [HIST];

   // Model: sweep activity, pending result time and the result on offer.
   bit              m_busy, m_hold, m_cont, m_ovf;
   int              m_addr, m_oaddr, m_data, m_gate, m_valid_at, m_done_at;
   logic [N_PX-1:0] m_mask;

   function automatic int lowestCh(input logic [N_PX-1:0] m);
      for (int i = 0; i < N_PX; i++) if (m[i]) return i;
      return -1;
   endfunction

   function automatic int nextCh(input logic [N_PX-1:0] m, input int after);
      for (int i = after + 1; i < N_PX; i++) if (m[i]) return i;
      return -1;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      cmp_count++;
      if (got !== exp) begin
         err_count++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic modelTick();
      int sum;
      if (m_busy && !m_hold && cyc == m_valid_at) begin
         sum = 0;
         for (int c = m_valid_at - m_gate; c < m_valid_at; c++)
            if (c >= 0 && c < HIST) sum += int'(pulse_hist[c]);
         m_data  = (sum > CNT_MAX) ? CNT_MAX : sum;
         m_ovf   = (sum > CNT_MAX);
         m_oaddr = m_addr;
         m_hold  = 1'b1;
      end
   endtask

   task automatic checkAll();
      logic [N_PX-1:0] es;
      es = '1;
      if (m_busy && !m_hold) es[m_addr] = 1'b0;
      checkOutput("busy", busy, m_busy);
      checkOutput("out_valid", out_valid, m_hold);
      checkOutput("px_addr", px_addr, m_addr);
      checkOutput("stop_osc", stop_osc, es);
      checkOutput("sweep_done", sweep_done, cyc == m_done_at);
      if (m_hold) begin
         checkOutput("out_data", out_data, m_data);
         checkOutput("out_addr", out_addr, m_oaddr);
         checkOutput("out_ovf", out_ovf, m_ovf);
      end
   endtask

   task automatic applyStimulus(input bit st, input bit ab, input bit cm, input logic [N_PX-1:0] mk,
                                input logic [GATE_W-1:0] gl, input bit pp, input bit rdy);
      int n;
      start = st; abort = ab; cont_mode = cm; ch_mask = mk; gate_len = gl;
      px_pulse = pp; out_ready = rdy;
      if (cyc < HIST) pulse_hist[cyc] = pp;
      if (ab) begin
         m_busy = 1'b0;
         m_hold = 1'b0;
      end else if (!m_busy) begin
         if (st && mk != '0) begin
            m_mask     = mk;
            m_gate     = (gl == '0) ? 1 : int'(gl);
            m_cont     = cm;
            m_addr     = lowestCh(mk);
            m_busy     = 1'b1;
            m_valid_at = cyc + 1 + SETTLE_CYC + m_gate;
         end
      end else if (m_hold && rdy) begin
         m_hold = 1'b0;
         n = nextCh(m_mask, m_addr);
         if (n >= 0) begin
            m_addr     = n;
            m_valid_at = cyc + 1 + SETTLE_CYC + m_gate;
         end else begin
            m_done_at = cyc + 1;
            if (m_cont) begin
               m_addr     = lowestCh(m_mask);
               m_valid_at = cyc + 1 + SETTLE_CYC + m_gate;
            end else begin
               m_busy = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      modelTick();
      checkAll();
   endtask

   task automatic doReset();
      start = 0; abort = 0; cont_mode = 0; ch_mask = '0; gate_len = '0;
      px_pulse = 0; out_ready = 0;
      rst = 1'b1;
      #1;
      m_busy = 0; m_hold = 0; m_addr = 0; m_done_at = -1;
      checkAll();
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_out_addr", out_addr, 0);
      checkOutput("rst_out_ovf", out_ovf, 0);
      @(posedge clk);
      #1;
      cyc++;
      rst = 1'b0;
      checkAll();
   endtask

   initial begin
      int t0, first, ndone, cap_data, cap_ovf, alt;
      cmp_count = 0; err_count = 0; cyc = 0;
      m_busy = 0; m_hold = 0; m_cont = 0; m_ovf = 0; m_addr = 0; m_oaddr = 0;
      m_data = 0; m_gate = 1; m_valid_at = -1; m_done_at = -1; m_mask = '0;
      rst = 1'b0;
      #1;
      doReset();

      // Single sweep over channels 0 and 2 with a constant pulse train.
      t0 = cyc; first = -1; ndone = 0;
      applyStimulus(1, 0, 0, 24'h000005, 16'd10, 1, 1);
      for (int i = 0; i < 40; i++) begin
         if (out_valid && first < 0) first = cyc;
         if (sweep_done) ndone++;
         applyStimulus(0, 0, 0, 24'h000005, 16'd10, 1, 1);
      end
      checkOutput("first_valid_cycle", first, t0 + 15);
      checkOutput("sweep_done_count", ndone, 1);

      // Back-pressure: result held for well over 20 cycles.
      applyStimulus(1, 0, 0, 24'h000010, 16'd6, 1, 0);
      for (int i = 0; i < 32; i++) applyStimulus(0, 0, 0, 24'hFFFFFF, 16'd6, 1'($urandom), 0);
      for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 24'hFFFFFF, 16'd6, 1, 1);

      // Saturation: 20 pulses into a 4-bit counter.
      cap_data = -1; cap_ovf = -1;
      applyStimulus(1, 0, 0, 24'h000100, 16'd20, 1, 1);
      for (int i = 0; i < 30; i++) begin
         if (out_valid) begin cap_data = out_data; cap_ovf = out_ovf; end
         applyStimulus(0, 0, 0, 24'h000100, 16'd20, 1, 1);
      end
      checkOutput("sat_data", cap_data, CNT_MAX);
      checkOutput("sat_ovf", cap_ovf, 1);

      // Continuous sweep over channels 0 and 23, then abort.
      alt = 0;
      applyStimulus(1, 0, 1, 24'h800001, 16'd3, 1, 1);
      for (int i = 0; i < 45; i++) begin
         if (out_valid) begin
            checkOutput("cont_addr", out_addr, alt);
            alt = (alt == 0) ? 23 : 0;
         end
         applyStimulus(0, 0, 0, 24'h000000, 16'd3, 1'($urandom), 1);
      end
      applyStimulus(1, 1, 0, 24'h000001, 16'd3, 1, 1);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 24'h000001, 16'd3, 1, 1);

      // Empty mask start, zero gate length, reset mid-count.
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 24'h000000, 16'd5, 1, 1);
      applyStimulus(1, 0, 0, 24'h000002, 16'd0, 1, 1);
      for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 24'h000002, 16'd0, 1'($urandom), 1);
      applyStimulus(1, 0, 0, 24'h000008, 16'd10, 1, 1);
      for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 24'h000008, 16'd10, 1, 1);
      doReset();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [N_PX-1:0] mk;
         mk = ($urandom_range(0, 7) == 0) ? '0 : N_PX'($urandom & $urandom);
         if ($urandom_range(0, 499) == 0) doReset();
         else applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0),
                            ($urandom_range(0, 3) == 0), mk, GATE_W'($urandom_range(0, 25)),
                            1'($urandom), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

endmodule

// File: doc/pixel_scan_ctrl.md
PIXEL_SCAN_CTRL -- requirements
Module: pixel_scan_ctrl

Interface
REQ-001 The block SHALL have parameter N_PX, default 24, meaning the number of pixel oscillator channels (2..32).
REQ-002 The block SHALL have parameter CNT_W, default 32, meaning the frequency counter width.
REQ-003 The block SHALL have parameter GATE_W, default 16, meaning the gate-length field width.
REQ-004 The block SHALL have parameter SETTLE_CYC, default 4, meaning the oscillator settle cycles before counting (>=1).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: sweep request pulse.
REQ-008 The block SHALL have port abort, input, 1 bit: terminate the sweep.
REQ-009 The block SHALL have port cont_mode, input, 1 bit: restart the sweep automatically after the last channel.
REQ-010 The block SHALL have port ch_mask, input, N_PX bits: enabled channels.
REQ-011 The block SHALL have port gate_len, input, GATE_W bits: count window in cycles.
REQ-012 The block SHALL have port px_pulse, input, 1 bit: synchronous one-cycle edge pulse from the selected pixel.
REQ-013 The block SHALL have port px_addr, output, AW=$clog2(N_PX) bits: selected channel.
REQ-014 The block SHALL have port stop_osc, output, N_PX bits: per-pixel oscillator off, active-high.
REQ-015 The block SHALL have ports out_data (output, CNT_W bits), out_addr (output, AW bits), out_ovf (output, 1 bit) and out_valid (output, 1 bit): the result channel.
REQ-016 The block SHALL have port out_ready, input, 1 bit: result accept.
REQ-017 The block SHALL have ports busy (output, 1 bit) and sweep_done (output, 1-cycle pulse).

Function
REQ-018 The FSM SHALL have states IDLE, SETTLE, COUNT and HOLD.
REQ-019 In IDLE, start=1 with ch_mask!=0 SHALL latch ch_mask, gate_len and cont_mode, select the lowest enabled channel, and enter SETTLE on the next edge.
REQ-020 start SHALL be ignored when ch_mask==0 and when not in IDLE.
REQ-021 A latched gate_len of 0 SHALL be treated as 1.
REQ-022 SETTLE SHALL last exactly SETTLE_CYC cycles, with stop_osc[px_addr]=0, all other stop_osc bits=1, and the counter cleared; the FSM SHALL then enter COUNT.
REQ-023 COUNT SHALL last exactly G (gate) cycles; the counter SHALL increment in each COUNT cycle where px_pulse=1.
REQ-024 The counter SHALL saturate at 2^CNT_W-1, and any further pulse in that window SHALL set the ovf flag for that window.
REQ-025 Leaving COUNT, the block SHALL load out_data, out_addr and out_ovf, set stop_osc to all ones, assert out_valid, and enter HOLD.
REQ-026 From start sampled in cycle 0, out_valid SHALL first be high in cycle 1+SETTLE_CYC+G.
REQ-027 While out_valid=1, out_data, out_addr and out_ovf SHALL stay stable; px_pulse SHALL be ignored in HOLD and IDLE.
REQ-028 The transfer SHALL complete on a cycle with out_valid=1 and out_ready=1; out_valid SHALL then drop on the next edge.
REQ-029 On transfer, if a higher-index enabled channel exists, the FSM SHALL select it and enter SETTLE.
REQ-030 On transfer at the last enabled channel, the block SHALL pulse sweep_done for one cycle, then either re-enter SETTLE at the lowest latched channel (latched cont_mode=1) or enter IDLE (latched cont_mode=0).
REQ-031 abort=1 in any state SHALL force IDLE on the next edge, clear out_valid, set stop_osc to all ones, and generate no sweep_done; abort SHALL take priority over start and over the transfer.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 ch_mask and gate_len changes mid-sweep SHALL take effect only at the next start.

Reset
REQ-034 While rst=1, the block SHALL asynchronously enter IDLE with px_addr=0, stop_osc all ones, out_data=0, out_addr=0, out_ovf=0, out_valid=0, busy=0, sweep_done=0, and the counter and latches zeroed.
REQ-035 After reset is released, the block SHALL wait for start; reset asserted mid-sweep SHALL discard any pending result.

Verification
REQ-036 Scenario single sweep: defaults, ch_mask=0x000005, gate_len=10, px_pulse=1 constantly, out_ready=1 -> results (addr 0, data 10) then (addr 2, data 10), first out_valid at cycle 15, one sweep_done, then IDLE.
REQ-037 Scenario back-pressure: out_ready=0 for 20 cycles during HOLD -> out_valid and out_data remain stable, stop_osc all ones, no further channel selected.
REQ-038 Scenario saturation: CNT_W=4, gate_len=20, px_pulse constant -> out_data=15, out_ovf=1.
REQ-039 Scenario continuous: cont_mode=1, ch_mask=0x800001 -> address sequence 0,23,0,23...; sweep_done follows each addr-23 transfer; abort -> IDLE next cycle with out_valid=0.
REQ-040 Scenario edge cases: start with ch_mask=0 -> busy stays 0; gate_len=0 -> window of 1 cycle; rst asserted during COUNT -> all outputs at reset values immediately.
